// File: rtl/mul_stream.sv
// Streaming pipelined multiplier with valid/ready handshake and sideband tag.
// Each stage carries a valid bit; empty stages refill even while downstream stalls.
module mul_stream #(
  parameter int LATENCY  = 4,
  parameter int A_BITS   = 32,
  parameter int B_BITS   = 32,
  parameter int TAG_BITS = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [A_BITS-1:0]        i_a,
  input  logic [B_BITS-1:0]        i_b,
  input  logic                     i_signed,
  input  logic [TAG_BITS-1:0]      i_tag,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [A_BITS+B_BITS-1:0] o_q,
  output logic [TAG_BITS-1:0]      o_tag,
  output logic                     o_busy
);

  localparam int W = A_BITS + B_BITS;

  logic [LATENCY-1:0]  v;
  logic [LATENCY-1:0]  adv;
  logic [W-1:0]        q   [LATENCY];
  logic [TAG_BITS-1:0] tag [LATENCY];

  logic [W-1:0] ext_a;
  logic [W-1:0] ext_b;
  logic [W-1:0] prod;

  assign ext_a = {{B_BITS{i_signed & i_a[A_BITS-1]}}, i_a};
  assign ext_b = {{A_BITS{i_signed & i_b[B_BITS-1]}}, i_b};
  assign prod  = ext_a * ext_b;

  // A stage may advance unless it and every stage ahead of it are full
  // while the consumer stalls; flattened to avoid a combinational chain.
  for (genvar k = 0; k < LATENCY; k++) begin : g_adv
    assign adv[k] = i_ready | ~(&v[LATENCY-1:k]);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        q[k]   <= '0;
        tag[k] <= '0;
      end
    end else begin
      if (adv[0]) begin
        v[0] <= i_valid;
        if (i_valid) begin
          q[0]   <= prod;
          tag[0] <= i_tag;
        end
      end
      // Payload only moves with a valid entry, so outputs stay put otherwise.
      for (int k = 1; k < LATENCY; k++) begin
        if (adv[k]) begin
          v[k] <= v[k-1];
          if (v[k-1]) begin
            q[k]   <= q[k-1];
            tag[k] <= tag[k-1];
          end
        end
      end
    end
  end

  assign o_ready = adv[0] & ~i_rst;
  assign o_valid = v[LATENCY-1];
  assign o_q     = q[LATENCY-1];
  assign o_tag   = tag[LATENCY-1];
  assign o_busy  = |v;

endmodule

// File: tb/tb_mul_stream.sv
// Self-checking bench for mul_stream: LATENCY=4 and LATENCY=1 instances
// share stimulus; each is checked against a transaction-level queue model.
module tb_mul_stream;

  logic        clk;
  logic        i_rst;
  logic        i_valid;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        i_signed;
  logic [3:0]  i_tag;
  logic        i_ready;

  logic [1:0]       ov;
  logic [1:0]       ordy;
  logic [1:0]       obusy;
  logic [1:0][63:0] oq;
  logic [1:0][3:0]  ot;

  int nchk;
  int nfail;
  int edges;

  typedef struct {
    logic [63:0] p;
    logic [3:0]  t;
    int          acc;
  } exp_t;

  exp_t sb [2][64];
  int   hd [2];
  int   tl [2];

  mul_stream #(.LATENCY(4)) dut4 (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(ordy[0]),
    .i_a(i_a), .i_b(i_b), .i_signed(i_signed), .i_tag(i_tag),
    .o_valid(ov[0]), .i_ready(i_ready), .o_q(oq[0]), .o_tag(ot[0]),
    .o_busy(obusy[0])
  );

  mul_stream #(.LATENCY(1)) dut1 (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(ordy[1]),
    .i_a(i_a), .i_b(i_b), .i_signed(i_signed), .i_tag(i_tag),
    .o_valid(ov[1]), .i_ready(i_ready), .o_q(oq[1]), .o_tag(ot[1]),
    .o_busy(obusy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic s);
    longint sa;
    longint sb_;
    if (s) begin
      sa  = longint'($signed(a));
      sb_ = longint'($signed(b));
      return 64'(sa * sb_);
    end
    return {32'h0, a} * {32'h0, b};
  endfunction

  task automatic chk(input string nm, input logic [63:0] obs,
                     input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", nm, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check against model, update at posedge.
  task automatic step(input logic v, input logic [31:0] a,
                      input logic [31:0] b, input logic s,
                      input logic [3:0] t, input logic r,
                      output logic acc0);
    logic [1:0] acc;
    logic [1:0] ret;
    logic       ev;
    logic       er;
    int         cnt;
    int         lat;
    @(negedge clk);
    i_valid  = v;
    i_a      = a;
    i_b      = b;
    i_signed = s;
    i_tag    = t;
    i_ready  = r;
    #1;
    for (int n = 0; n < 2; n++) begin
      lat = (n == 0) ? 4 : 1;
      cnt = tl[n] - hd[n];
      ev  = (cnt > 0) && (edges - sb[n][hd[n] % 64].acc >= lat - 1);
      er  = !i_rst && (r || cnt < lat);
      chk($sformatf("valid%0d", n), 64'(ov[n]), 64'(ev));
      chk($sformatf("ready%0d", n), 64'(ordy[n]), 64'(er));
      chk($sformatf("busy%0d", n), 64'(obusy[n]), 64'(cnt > 0));
      if (ev) begin
        chk($sformatf("q%0d", n), oq[n], sb[n][hd[n] % 64].p);
        chk($sformatf("tag%0d", n), 64'(ot[n]), 64'(sb[n][hd[n] % 64].t));
      end
      acc[n] = v && er;
      ret[n] = ev && r;
    end
    acc0 = acc[0];
    @(posedge clk);
    edges++;
    for (int n = 0; n < 2; n++) begin
      if (ret[n]) hd[n]++;
      if (acc[n]) begin
        sb[n][tl[n] % 64].p   = ref_mul(a, b, s);
        sb[n][tl[n] % 64].t   = t;
        sb[n][tl[n] % 64].acc = edges;
        tl[n]++;
      end
    end
  endtask

  task automatic check_reset_outputs(input string ph);
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("%s_valid%0d", ph, n), 64'(ov[n]), 64'(0));
      chk($sformatf("%s_busy%0d", ph, n), 64'(obusy[n]), 64'(0));
      chk($sformatf("%s_ready%0d", ph, n), 64'(ordy[n]), 64'(0));
      chk($sformatf("%s_q%0d", ph, n), oq[n], 64'(0));
      chk($sformatf("%s_tag%0d", ph, n), 64'(ot[n]), 64'(0));
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    i_rst   = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    #1;
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("rel_ready%0d", n), 64'(ordy[n]), 64'(1));
      chk($sformatf("rel_q%0d", n), oq[n], 64'(0));
    end
  endtask

  task automatic idle(input int n, input logic r);
    logic x;
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, r, x);
  endtask

  initial begin
    logic        acc;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    int          tg;
    int          naccepted;
    nchk = 0; nfail = 0; edges = 0;
    hd[0] = 0; hd[1] = 0; tl[0] = 0; tl[1] = 0;
    i_rst = 1'b1; i_valid = 1'b0; i_a = '0; i_b = '0;
    i_signed = 1'b0; i_tag = '0; i_ready = 1'b1;
    #12;
    check_reset_outputs("por");
    release_reset();

    // Latency and streaming
    step(1'b1, 32'd3, 32'd5, 1'b0, 4'd1, 1'b1, acc);
    step(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4'd2, 1'b1, acc);
    idle(6, 1'b1);

    // Signed versus unsigned with the same operands
    step(1'b1, 32'hFFFFFFFF, 32'd7, 1'b1, 4'd3, 1'b1, acc);
    step(1'b1, 32'hFFFFFFFF, 32'd7, 1'b0, 4'd4, 1'b1, acc);
    idle(6, 1'b1);

    // Backpressure fill: tags 0..5 offered continuously while stalled
    tg = 0;
    naccepted = 0;
    ra = $urandom; rb = $urandom; rs = 1'($urandom);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, ra, rb, rs, 4'(tg), 1'b0, acc);
      if (acc) begin
        naccepted++;
        tg++;
        ra = $urandom; rb = $urandom; rs = 1'($urandom);
      end
    end
    chk("fill_count", 64'(naccepted), 64'(4));
    while (tg < 6) begin
      step(1'b1, ra, rb, rs, 4'(tg), 1'b1, acc);
      if (acc) begin
        tg++;
        ra = $urandom; rb = $urandom; rs = 1'($urandom);
      end
    end
    idle(6, 1'b1);

    // Bubble collapse
    step(1'b1, 32'd11, 32'd13, 1'b0, 4'd0, 1'b1, acc);
    idle(2, 1'b1);
    step(1'b1, 32'd17, 32'd19, 1'b0, 4'd1, 1'b0, acc);
    idle(4, 1'b0);
    for (int i = 0; i < 4; i++)
      step(1'b1, $urandom, $urandom, 1'($urandom), 4'(2 + i), 1'b0, acc);
    idle(6, 1'b1);

    // LATENCY=1 focus: full stream, then i_ready toggling
    for (int i = 0; i < 6; i++)
      step(1'b1, $urandom, $urandom, 1'($urandom), 4'(i), 1'b1, acc);
    for (int i = 0; i < 16; i++)
      step(1'b1, $urandom, $urandom, 1'($urandom), 4'(i), 1'(i % 2), acc);
    idle(6, 1'b1);

    // Random traffic
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
           1'($urandom), 4'($urandom), 1'($urandom_range(0, 2) != 0), acc);
    idle(6, 1'b1);

    // Reset mid-stream with 3 entries in flight
    for (int i = 0; i < 3; i++)
      step(1'b1, $urandom, $urandom, 1'b0, 4'(9 + i), 1'b0, acc);
    @(negedge clk);
    i_valid = 1'b1;
    #2;
    i_rst = 1'b1;
    #1;
    check_reset_outputs("mid");
    hd[0] = 0; hd[1] = 0; tl[0] = 0; tl[1] = 0;
    idle(2, 1'b1);
    release_reset();
    idle(6, 1'b1);
    for (int i = 0; i < 4; i++)
      step(1'b1, $urandom, $urandom, 1'($urandom), 4'(i), 1'b1, acc);
    idle(6, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/mul_stream.md
# mul_stream

Pipelined multiplier with valid/ready flow control, per-transaction signed/unsigned mode and a sideband tag. It is the streaming successor of the fixed-latency free-running multiplier: it has the same parametrised depth, but each pipeline stage carries a valid bit, stalls under backpressure and collapses bubbles. It sits in the datapath between operand-fetch logic and any consumer that can apply backpressure.

## Interface

Parameters:
- `LATENCY`, default 4: number of register stages, ≥1.
- `A_BITS`, default 32: width of operand A.
- `B_BITS`, default 32: width of operand B.
- `TAG_BITS`, default 4: width of the opaque sideband tag, ≥1.

Ports:
- `i_clk` input 1: clock; all logic is on the rising edge.
- `i_rst` input 1: reset, asynchronous, active-high.
- `i_valid` input 1: the input transaction is present.
- `o_ready` output 1: the block accepts the input this cycle.
- `i_a` input A_BITS: operand A.
- `i_b` input B_BITS: operand B.
- `i_signed` input 1: 1 = both operands are two's complement; 0 = both are unsigned.
- `i_tag` input TAG_BITS: tag that travels alongside the product.
- `o_valid` output 1: result present.
- `i_ready` input 1: the consumer accepts the result.
- `o_q` output A_BITS+B_BITS: the full-width product.
- `o_tag` output TAG_BITS: the tag of the result.
- `o_busy` output 1: at least one stage holds a valid entry.

## Operation

- Stages are numbered 0..LATENCY-1. Each stage holds `v[k]`, `q[k]` and `tag[k]`. Stage LATENCY-1 drives `o_valid`, `o_q` and `o_tag`.
- Acceptance: a transaction is accepted on an edge where `i_valid && o_ready`. On acceptance, stage 0 loads the product of `i_a` and `i_b`, and also loads `i_tag`.
- Arithmetic:
  - `i_signed=1`: operands are sign-extended to A_BITS+B_BITS and the product is exact two's complement.
  - `i_signed=0`: operands are zero-extended.
  - There is no truncation and no overflow is possible.
- Advance rule, bubble-collapsing:
  - `adv[LATENCY-1] = !v[LATENCY-1] || i_ready`.
  - `adv[k] = !v[k] || adv[k+1]` for k < LATENCY-1.
  - `o_ready = adv[0]` while `i_rst` is low; `o_ready` is forced to 0 while `i_rst` is high.
- Stage update on each edge:
  - Stage k>0 with `adv[k]=1` loads `v[k-1]`, `q[k-1]` and `tag[k-1]`.
  - Stage 0 with `adv[0]=1` loads `i_valid` and the input data.
  - A stage with `adv=0` holds its contents.
- A bubble in stage k is filled on the next edge even when downstream stages are stalled.
- The payload registers of an empty stage may load don't-care data, but `o_q` and `o_tag` must hold stable while `o_valid=1 && !i_ready`.
- `o_busy` is the OR of all `v[k]`.
- The mode is fixed per transaction. Mixing `i_signed` on consecutive transactions is legal, and each result uses its own mode.

## Timing

- Reset, asynchronous: all `v[k]`, `q[k]` and `tag[k]` are cleared immediately. The output values during and after reset are:
  - `o_valid=0`, `o_q=0`, `o_tag=0`, `o_busy=0`.
  - `o_ready=0` while `i_rst` is high; `o_ready=1` after deassertion.
- Reset mid-operation discards all in-flight transactions; none reappear after reset.
- Latency without stall: a transaction accepted on edge t is presented with `o_valid=1` after edge t+LATENCY-1. With `LATENCY=1`, the result is visible in the cycle right after the accepting edge.
- Throughput: with `i_ready` held at 1, one transaction is accepted and one is retired per cycle, with no bubbles.
- Full pipe with `i_ready=1` and `i_valid=1`: accept and retire happen on the same edge, and `o_ready` stays at 1.
- Full pipe with `i_ready=0`:
  - `o_ready=0` combinationally.
  - Contents are frozen.
  - `i_valid` is ignored and there is no data loss.
- Capacity is exactly LATENCY transactions. When all stages are valid and `i_ready=0`, the block is full.
- `o_ready` depends combinationally on `i_ready` through the `adv` chain. There is no path from `i_valid` to `o_ready`.
- Results leave in acceptance order. Tags are returned unchanged and in order.

## Test plan

- **Reset values.** Assert `i_rst` mid-stream with 3 entries in flight. Required response: `o_valid`, `o_busy` and `o_ready` drop immediately; `o_q=0` and `o_tag=0`. After release, `o_ready=1` and no stale result ever appears.
- **Latency and streaming.** Use LATENCY=4 with `i_ready=1`. Feed `a=3, b=5, tag=1`, then `a=0xFFFFFFFF, b=0xFFFFFFFF, tag=2` unsigned, on consecutive cycles. Required response: `o_q=15` (tag 1) appears after the 4th edge, and `o_q=0xFFFFFFFE00000001` (tag 2) appears on the next cycle.
- **Signed mode.** Use `i_signed=1`, `a=0xFFFFFFFF` (−1), `b=7`. Required response: `o_q=0xFFFFFFFFFFFFFFF9` (−7). The same operands with `i_signed=0` give `0x00000006FFFFFFF9`.
- **Backpressure fill.** Hold `i_ready=0` and drive `i_valid=1` continuously with tags 0..5. Required response:
  - Exactly 4 transactions are accepted and `o_ready` then goes to 0.
  - `o_q` and `o_tag` (tag 0) stay stable while stalled.
  - After `i_ready=1`, tags 0..5 emerge in order with none lost and none duplicated.
- **Bubble collapse.** Accept tag 0, idle 2 cycles, accept tag 1, with `i_ready=0` from the moment tag 0 reaches the output. Required response: tag 1 advances until it sits in the stage behind tag 0; `o_ready` stays at 1 until all 4 stages are valid.
- **LATENCY=1 instance.** Apply a full-throughput stream, then toggle `i_ready` every cycle. Required response:
  - `o_ready` follows `!o_valid || i_ready` exactly.
  - Products are correct.
  - Throughput is 1 transaction per `i_ready`-high cycle.
